apb_fifo_slave: RTL and testbench
=================================

# apb_fifo_slave

APB2-style slave that terminates the 8-bit-address / 32-bit-data APB bus driven by the bench master. It exposes a small register bank and an 8-deep write-data FIFO, drained through a valid/ready stream port. Illegal bus sequences are detected and reported in a sticky status bit instead of being executed, so protocol-error stimulus from the master produces checkable behaviour.

## Interface
- DEPTH, 8, FIFO entries; power of two.
- clk  input  1  bus and core clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- paddr  input  8  byte address; paddr[1:0] ignored.
- pwrite  input  1  1 = write, 0 = read.
- psel  input  1  slave select.
- penable  input  1  access phase.
- pwdata  input  32  write data.
- prdata  output  32  read data, registered.
- out_valid  output  1  FIFO head valid.
- out_data  output  32  FIFO head word.
- out_ready  input  1  downstream accept.

## Operation
- Register map:
  - 0x00 CTRL, rw: [0] en, [1] flush (self-clearing, always reads 0).
  - 0x04 STATUS, ro except W1C bits:
    - [3:0] level, [4] empty, [5] full.
    - [8] overflow, sticky.
    - [9] perr, sticky.
    - Writing 1 to bit 8 or bit 9 clears that bit.
  - 0x08 TXDATA, wo: push; reads return 0.
  - 0x0C SCRATCH, rw.
  - 0x10 PUSHCNT, ro: [15:0] count of accepted pushes, wraps at 0xFFFF->0.
  - All other addresses read 0; writes to them are ignored.
- Bus tracker FSM, updated on every posedge from psel/penable:
  - IDLE -> SETUP: psel=1, penable=0.
  - IDLE -> IDLE, perr set: psel=1, penable=1 (enable without setup).
  - SETUP -> ACCESS: psel=1, penable=1, with paddr and pwrite equal to the values latched at setup. The transfer executes.
  - SETUP -> ACCESS, perr set, transfer discarded: paddr or pwrite differs from the setup latch.
  - SETUP -> IDLE, perr set: psel=0 (abandoned).
  - SETUP -> SETUP: repeated setup; re-latches paddr/pwrite; no error.
  - ACCESS -> SETUP (back-to-back), or ACCESS -> IDLE.
  - ACCESS with psel=1, penable=1 again: perr set, no second execution.
- Reads: prdata is loaded at the SETUP edge from the decoded address and held until the next read setup. Reads have no side effects.
- Writes: commit at the ACCESS edge.
- FIFO push (TXDATA write):
  - Accepted when level < DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the word is dropped, overflow is set, and PUSHCNT does not increment.
- FIFO pop: out_valid && out_ready. out_valid = en && !empty.
- Flush (CTRL write with [1]=1):
  - Empties the FIFO and suppresses any same-cycle pop.
  - en is written from the same data.
  - overflow and PUSHCNT are unaffected.
- Simultaneous W1C clear and a new set event on the same bit: the set wins.

## Timing
- Reset values:
  - prdata 0, out_valid 0, out_data 0.
  - CTRL 0, SCRATCH 0, PUSHCNT 0, overflow 0, perr 0.
  - FIFO empty; FSM in IDLE.
- No wait states (no pready). A read returns data in the access phase; data remains valid one cycle after the access edge.
- A pushed word is visible on out_valid/out_data in the cycle after the access edge.
- Pop advances the head in the next cycle. Sustained throughput is 1 word/cycle.
- out_valid, out_data and prdata depend only on flops; there is no combinational path from APB inputs.
- Reset asserted mid-transfer or mid-drain returns everything to reset values immediately, and the FSM goes to IDLE.

## Structure
- Package apb_fifo_slave_pkg holds:
  - register offsets;
  - CTRL/STATUS bit indices;
  - the FSM enum (IDLE, SETUP, ACCESS);
  - the DEPTH default and the level width ($clog2(DEPTH)+1).
- Sub-module apb_fifo_slave_fifo: synchronous FIFO with push/pop/flush, level, full, empty, and a registered head.
- The top-level module contains the bus FSM, address decode and registers.

## Test plan
- Reset:
  - All outputs are 0.
  - Read STATUS -> 0x0000_0010.
  - Read PUSHCNT -> 0.
- Register access:
  - Write SCRATCH 0xA5A5_1234, read it back -> 0xA5A5_1234.
  - Read 0x20 -> 0.
  - Write CTRL 0x3, read it back -> 0x1.
- Overflow:
  - With en=0, write TXDATA 1..9.
  - STATUS -> 0x0000_0128; PUSHCNT -> 8.
  - Write CTRL 0x1 with out_ready=1 -> out_data 1..8 on 8 consecutive cycles, then out_valid=0.
- Protocol error (psel):
  - Write SCRATCH 0x55 with setup_psel=0 -> SCRATCH unchanged; STATUS[9]=1.
  - Write STATUS 0x200 -> STATUS[9]=0.
- Protocol error (pwrite):
  - Write TXDATA with setup_pwrite=0 -> level unchanged; perr=1.
- Flush and full-boundary push:
  - Push 3 words, write CTRL 0x2 -> level 0, empty=1.
  - Fill to 8 with en=1 and out_ready held 0.
  - Raise out_ready and push on the same edge as a pop -> push accepted, level stays 8, overflow stays 0.

Source files
------------

// File: rtl/apb_fifo_slave_pkg.sv
// Shared definitions for the APB FIFO slave: register map, bit positions,
// bus tracker states and the address decoder.
package apb_fifo_slave_pkg;

   localparam int FIFO_DEPTH = 8;
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

   localparam logic [7:0] ADDR_CTRL    = 8'h00;
   localparam logic [7:0] ADDR_STATUS  = 8'h04;
   localparam logic [7:0] ADDR_TXDATA  = 8'h08;
   localparam logic [7:0] ADDR_SCRATCH = 8'h0C;
   localparam logic [7:0] ADDR_PUSHCNT = 8'h10;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_FLUSH = 1;
   localparam int ST_EMPTY   = 4;
   localparam int ST_FULL    = 5;
   localparam int ST_OVF     = 8;
   localparam int ST_PERR    = 9;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} bus_state_e;

   typedef enum logic [2:0] {
      REG_CTRL, REG_STATUS, REG_TXDATA, REG_SCRATCH, REG_PUSHCNT, REG_NONE
   } reg_sel_e;

   // The two low address bits are don't-care, so decode on word address.
   function automatic reg_sel_e decode(input logic [7:0] addr);
      case ({addr[7:2], 2'b00})
         ADDR_CTRL:    return REG_CTRL;
         ADDR_STATUS:  return REG_STATUS;
         ADDR_TXDATA:  return REG_TXDATA;
         ADDR_SCRATCH: return REG_SCRATCH;
         ADDR_PUSHCNT: return REG_PUSHCNT;
         default:      return REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/apb_fifo_slave_fifo.sv
// Synchronous FIFO with flush and a registered head word; push is assumed
// pre-qualified by the caller (never issued when full without a pop).
module apb_fifo_slave_fifo #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [DATA_W-1:0]        i_wdata,
   output logic [DATA_W-1:0]        o_head,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_full,
   output logic                     o_empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LW    = PTR_W + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_rd, r_wr, w_rd_nxt;
   logic [LW-1:0]     r_cnt, w_cnt_nxt;
   logic [DATA_W-1:0] r_head, w_head_nxt;
   logic              w_push, w_pop;

   assign w_push  = i_push && !i_flush;
   assign w_pop   = i_pop && !o_empty && !i_flush;
   assign o_level = r_cnt;
   assign o_full  = (r_cnt == LW'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_head  = r_head;

   // Next head: the slot being written this cycle bypasses the array.
   always_comb begin
      w_rd_nxt   = r_rd + PTR_W'(w_pop);
      w_cnt_nxt  = r_cnt + LW'(w_push) - LW'(w_pop);
      w_head_nxt = r_mem[w_rd_nxt];
      if (i_flush || w_cnt_nxt == '0) begin
         w_head_nxt = '0;
      end else if (w_push && w_rd_nxt == r_wr) begin
         w_head_nxt = i_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd   <= '0;
         r_wr   <= '0;
         r_cnt  <= '0;
         r_head <= '0;
      end else begin
         r_head <= w_head_nxt;
         if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
         end else begin
            r_rd  <= w_rd_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_push) r_wr <= r_wr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_wdata;
   end

endmodule

// File: rtl/apb_fifo_slave.sv
// APB2 slave with a register bank and a write-data FIFO drained by a
// valid/ready stream; illegal bus sequences set sticky perr and never execute.
module apb_fifo_slave
   import apb_fifo_slave_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  paddr,
   input  logic        pwrite,
   input  logic        psel,
   input  logic        penable,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        out_valid,
   output logic [31:0] out_data,
   input  logic        out_ready
);
   localparam int LW = $clog2(DEPTH) + 1;

   bus_state_e    r_state, w_state_nxt;
   logic [5:0]    r_addr;
   logic          r_wr;
   logic [31:0]   r_prdata, r_scratch, w_rdata, w_status;
   logic [15:0]   r_pushcnt;
   logic          r_en, r_ovf, r_perr;
   logic          w_latch, w_exec, w_perr_bus;
   logic          w_wr_exec, w_flush, w_push_req, w_push_ok, w_pop, w_ovf_set;
   logic          w_full, w_empty;
   logic [LW-1:0] w_level;
   reg_sel_e      w_wsel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_exec      = 1'b0;
      w_perr_bus  = 1'b0;
      case (r_state)
         IDLE: begin
            if (psel && !penable) begin
               w_state_nxt = SETUP;
               w_latch     = 1'b1;
            end else if (psel && penable) begin
               w_perr_bus  = 1'b1;
            end
         end
         SETUP: begin
            if (!psel) begin
               w_state_nxt = IDLE;
               w_perr_bus  = 1'b1;
            end else if (!penable) begin
               w_latch     = 1'b1;
            end else begin
               w_state_nxt = ACCESS;
               if (paddr[7:2] == r_addr && pwrite == r_wr) w_exec = 1'b1;
               else                                         w_perr_bus = 1'b1;
            end
         end
         ACCESS: begin
            if (!psel) begin
               w_state_nxt = IDLE;
            end else if (!penable) begin
               w_state_nxt = SETUP;
               w_latch     = 1'b1;
            end else begin
               w_perr_bus  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_wsel     = decode({r_addr, 2'b00});
   assign w_wr_exec  = w_exec && r_wr;
   assign w_flush    = w_wr_exec && (w_wsel == REG_CTRL) && pwdata[CTRL_FLUSH];
   assign out_valid  = r_en && !w_empty;
   assign w_pop      = out_valid && out_ready && !w_flush;
   assign w_push_req = w_wr_exec && (w_wsel == REG_TXDATA);
   assign w_push_ok  = w_push_req && (!w_full || w_pop);
   assign w_ovf_set  = w_push_req && !w_push_ok;
   assign prdata     = r_prdata;

   always_comb begin
      w_status              = '0;
      w_status[LW-1:0]      = w_level;
      w_status[ST_EMPTY]    = w_empty;
      w_status[ST_FULL]     = w_full;
      w_status[ST_OVF]      = r_ovf;
      w_status[ST_PERR]     = r_perr;
   end

   always_comb begin
      w_rdata = '0;
      case (decode(paddr))
         REG_CTRL:    w_rdata = {31'b0, r_en};
         REG_STATUS:  w_rdata = w_status;
         REG_SCRATCH: w_rdata = r_scratch;
         REG_PUSHCNT: w_rdata = {16'b0, r_pushcnt};
         default:     w_rdata = '0;
      endcase
   end

   // Set events take priority over a same-cycle W1C clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr    <= '0;
         r_wr      <= 1'b0;
         r_prdata  <= '0;
         r_en      <= 1'b0;
         r_scratch <= '0;
         r_pushcnt <= '0;
         r_ovf     <= 1'b0;
         r_perr    <= 1'b0;
      end else begin
         if (w_latch) begin
            r_addr <= paddr[7:2];
            r_wr   <= pwrite;
            if (!pwrite) r_prdata <= w_rdata;
         end
         if (w_wr_exec && w_wsel == REG_CTRL)    r_en      <= pwdata[CTRL_EN];
         if (w_wr_exec && w_wsel == REG_SCRATCH) r_scratch <= pwdata;
         if (w_push_ok)                          r_pushcnt <= r_pushcnt + 16'd1;
         if (w_ovf_set)
            r_ovf <= 1'b1;
         else if (w_wr_exec && w_wsel == REG_STATUS && pwdata[ST_OVF])
            r_ovf <= 1'b0;
         if (w_perr_bus)
            r_perr <= 1'b1;
         else if (w_wr_exec && w_wsel == REG_STATUS && pwdata[ST_PERR])
            r_perr <= 1'b0;
      end
   end

   apb_fifo_slave_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (32)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push_ok),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_wdata (pwdata),
      .o_head  (out_data),
      .o_level (w_level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Directed plus randomized bench for apb_fifo_slave against a queue-based
// register/FIFO model.
module tb_apb_fifo_slave;
   import apb_fifo_slave_pkg::*;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  paddr = '0;
   logic        pwrite = 1'b0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready = 1'b0;

   int n_pass = 0;
   int n_total = 0;

   logic [31:0] q[$];
   logic        m_en, m_ovf, m_perr;
   logic [31:0] m_scratch;
   logic [15:0] m_pushcnt;

   apb_fifo_slave #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .paddr     (paddr),
      .pwrite    (pwrite),
      .psel      (psel),
      .penable   (penable),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
   endtask

   function automatic void m_reset();
      q.delete();
      m_en = 0; m_ovf = 0; m_perr = 0; m_scratch = 0; m_pushcnt = 0;
   endfunction

   // Effect of a legal write with no concurrent pop.
   function automatic void m_write(input logic [7:0] a, input logic [31:0] d);
      case (a[7:2])
         6'h00: begin m_en = d[0]; if (d[1]) q.delete(); end
         6'h01: begin if (d[8]) m_ovf = 0; if (d[9]) m_perr = 0; end
         6'h02: begin
            if (q.size() < DEPTH) begin q.push_back(d); m_pushcnt++; end
            else m_ovf = 1;
         end
         6'h03: m_scratch = d;
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] m_status();
      int n = q.size();
      return 32'(n) + ((n == 0) ? 32'h10 : 32'h0) + ((n == DEPTH) ? 32'h20 : 32'h0)
           + (m_ovf ? 32'h100 : 32'h0) + (m_perr ? 32'h200 : 32'h0);
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] a);
      case (a[7:2])
         6'h00:   return {31'b0, m_en};
         6'h01:   return m_status();
         6'h03:   return m_scratch;
         6'h04:   return {16'b0, m_pushcnt};
         default: return 32'h0;
      endcase
   endfunction

   task automatic apb_write(input logic [7:0] a, input logic [31:0] d,
                            input bit s_psel = 1'b1, input bit s_pwr = 1'b1,
                            input bit hold = 1'b0, input bit rdy = 1'b0);
      @(posedge clk); #1;
      psel = s_psel; penable = 1'b0; paddr = a; pwrite = s_pwr; pwdata = d;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; out_ready = rdy;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (hold) begin @(posedge clk); #1; end
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; paddr = a; pwrite = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      d = prdata;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [7:0] a);
      logic [31:0] d;
      apb_read(a, d);
      check(tag, d, m_read(a));
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      apb_write(a, d);
      m_write(a, d);
   endtask

   task automatic drain_check(input string tag);
      out_ready = 1'b1;
      while (q.size() > 0) begin
         @(negedge clk);
         check({tag, "_vld"}, {31'b0, out_valid}, 32'h1);
         check({tag, "_data"}, out_data, q.pop_front());
      end
      @(negedge clk);
      check({tag, "_end"}, {31'b0, out_valid}, 32'h0);
      out_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d;
      logic [7:0]  ua;
      int          n;

      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {31'b0, out_valid}, 32'h0);
      check("rst_data", out_data, 32'h0);
      check("rst_prdata", prdata, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      read_check("rst_status", ADDR_STATUS);
      read_check("rst_pushcnt", ADDR_PUSHCNT);

      wr(ADDR_SCRATCH, 32'hA5A5_1234);
      read_check("scratch_rb", ADDR_SCRATCH);
      read_check("unmapped_20", 8'h20);
      wr(ADDR_CTRL, 32'h3);
      read_check("ctrl_rb", ADDR_CTRL);

      wr(ADDR_CTRL, 32'h0);
      for (int i = 1; i <= 9; i++) wr(ADDR_TXDATA, 32'(i));
      read_check("ovf_status", ADDR_STATUS);
      read_check("ovf_pushcnt", ADDR_PUSHCNT);
      wr(ADDR_CTRL, 32'h1);
      drain_check("ovf_drain");

      apb_write(ADDR_SCRATCH, 32'h55, 1'b0);
      m_perr = 1;
      read_check("perr_psel_scratch", ADDR_SCRATCH);
      read_check("perr_psel_status", ADDR_STATUS);
      wr(ADDR_STATUS, 32'h200);
      read_check("perr_clear", ADDR_STATUS);

      apb_write(ADDR_TXDATA, 32'hDEAD_0001, 1'b1, 1'b0);
      m_perr = 1;
      read_check("perr_pwrite_status", ADDR_STATUS);
      apb_write(ADDR_TXDATA, 32'hBEEF_0002, 1'b1, 1'b1, 1'b1);
      m_write(ADDR_TXDATA, 32'hBEEF_0002);
      m_perr = 1;
      read_check("perr_hold_status", ADDR_STATUS);
      #1 check("hold_head", out_data, q[0]);
      wr(ADDR_STATUS, 32'h300);
      read_check("w1c_both", ADDR_STATUS);

      wr(ADDR_TXDATA, 32'h1111);
      wr(ADDR_TXDATA, 32'h2222);
      read_check("pre_flush_status", ADDR_STATUS);
      wr(ADDR_CTRL, 32'h2);
      read_check("flush_status", ADDR_STATUS);
      wr(ADDR_CTRL, 32'h1);
      for (int i = 0; i < DEPTH; i++) wr(ADDR_TXDATA, $urandom);
      read_check("full_status", ADDR_STATUS);
      d = $urandom;
      apb_write(ADDR_TXDATA, d, 1'b1, 1'b1, 1'b0, 1'b1);
      void'(q.pop_front());
      q.push_back(d);
      m_pushcnt++;
      read_check("push_pop_status", ADDR_STATUS);
      read_check("push_pop_pushcnt", ADDR_PUSHCNT);
      #1 check("push_pop_head", out_data, q[0]);
      wr(ADDR_TXDATA, 32'hFFFF_0000);
      read_check("full_drop_status", ADDR_STATUS);
      drain_check("full_drain");

      wr(ADDR_CTRL, 32'h0);
      wr(ADDR_STATUS, 32'h100);
      for (int it = 0; it < 4; it++) begin
         d = $urandom;
         wr(ADDR_SCRATCH, d);
         read_check("rnd_scratch", ADDR_SCRATCH);
         ua = 8'($urandom_range(5, 63) << 2);
         wr(ua, $urandom);
         read_check("rnd_unmapped", ua);
         read_check("rnd_scratch_kept", ADDR_SCRATCH);
         n = $urandom_range(1, 10);
         for (int k = 0; k < n; k++) wr(ADDR_TXDATA, $urandom);
         read_check("rnd_status", ADDR_STATUS);
         read_check("rnd_pushcnt", ADDR_PUSHCNT);
         wr(ADDR_CTRL, 32'h1);
         drain_check("rnd_drain");
         wr(ADDR_CTRL, 32'h0);
         wr(ADDR_STATUS, 32'h100);
      end

      for (int k = 0; k < 5; k++) wr(ADDR_TXDATA, $urandom);
      wr(ADDR_CTRL, 32'h1);
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("mid_drain_data", out_data, q.pop_front());
      end
      #2 rst_n = 1'b0;
      #1;
      m_reset();
      check("arst_valid", {31'b0, out_valid}, 32'h0);
      check("arst_data", out_data, 32'h0);
      check("arst_prdata", prdata, 32'h0);
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      read_check("arst_status", ADDR_STATUS);
      read_check("arst_pushcnt", ADDR_PUSHCNT);
      read_check("arst_scratch", ADDR_SCRATCH);
      read_check("arst_ctrl", ADDR_CTRL);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
